// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared scheduler state encoding and timeout counter width
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } tx_state_t;

  localparam int TO_W             = 5;
  localparam int BUSY_TIMEOUT_DEF = 15;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way requester select: locked owner first, else round-robin
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       locked,
  input  logic       owner,
  input  logic       rr_ptr,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    if (locked) begin
      sel = owner;
    end else if (&valid) begin
      sel = rr_ptr;
    end else begin
      sel = valid[1];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - arbitrates two byte requesters onto one buart write port
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int LOCK_EN      = 1,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       uart_wr,
  output logic [7:0] uart_tx_data,
  input  logic       uart_busy,
  output logic       owner,
  output logic       locked,
  output logic       err_timeout
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUSY_TIMEOUT - 1);

  tx_state_t       r_state;
  logic            r_wr;
  logic [7:0]      r_tx_data;
  logic            r_owner;
  logic            r_rr_ptr;
  logic            r_locked;
  logic            r_err;
  logic [TO_W-1:0] r_cnt;

  logic       w_sel;
  logic       w_elig;
  logic       w_accept;
  logic       w_last;
  logic [7:0] w_data;

  rr_arb2 u_arb (
    .valid  ({req1_valid, req0_valid}),
    .locked (r_locked),
    .owner  (r_owner),
    .rr_ptr (r_rr_ptr),
    .sel    (w_sel)
  );

  // While locked, only the owner's valid can open the gate.
  assign w_elig     = r_locked ? (r_owner ? req1_valid : req0_valid)
                               : (req0_valid | req1_valid);
  assign w_accept   = (r_state == ST_IDLE) & ~uart_busy & w_elig;
  assign req0_ready = w_accept & ~w_sel;
  assign req1_ready = w_accept & w_sel;
  assign w_last     = w_sel ? req1_last : req0_last;
  assign w_data     = w_sel ? req1_data : req0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_tx_data <= 8'h00;
      r_owner   <= 1'b0;
      r_rr_ptr  <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data <= w_data;
            r_owner   <= w_sel;
            r_wr      <= 1'b1;
            r_state   <= ST_SEND;
            if (LOCK_EN != 0) r_locked <= ~w_last;
            if (w_last || (LOCK_EN == 0)) r_rr_ptr <= ~w_sel;
          end
        end
        ST_SEND: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A missing busy is treated as sent; lock and rr state are left alone.
          if (uart_busy) begin
            r_state <= ST_WAIT_IDLE;
          end else if (r_cnt >= TO_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!uart_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_wr      = r_wr;
  assign uart_tx_data = r_tx_data;
  assign owner        = r_owner;
  assign locked       = r_locked;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench with timeline reference model
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v [2];
  logic [7:0] d [2];
  logic       l [2];
  logic       rdy0, rdy1, wr, busy, owner, locked, err;
  logic [7:0] txd;

  logic       nv0, nv1, nrdy0, nrdy1, n_wr, nbusy, n_owner, n_locked, n_err;
  logic [7:0] n_txd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       own;
    int         wr_cyc;
  } exp_t;

  exp_t       q [$];
  logic [7:0] log_q [$];
  int         ng [$];
  int         wr_count = 0;
  int         force_l  = -1;
  int         free_cyc = 0;
  int         err_cyc  = 32'h7fffffff;
  int         b_start  = -1;
  int         b_end    = -2;
  logic       m_locked = 1'b0, m_owner = 1'b0, m_rr = 1'b0;
  logic [7:0] m_data   = 8'h00;

  uart_tx_sched #(.LOCK_EN(1), .BUSY_TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_data(d[0]), .req0_last(l[0]), .req0_ready(rdy0),
    .req1_valid(v[1]), .req1_data(d[1]), .req1_last(l[1]), .req1_ready(rdy1),
    .uart_wr(wr), .uart_tx_data(txd), .uart_busy(busy),
    .owner(owner), .locked(locked), .err_timeout(err)
  );

  uart_tx_sched #(.LOCK_EN(0), .BUSY_TIMEOUT(15)) u_nolock (
    .clk(clk), .reset(reset),
    .req0_valid(nv0), .req0_data(8'h10), .req0_last(1'b0), .req0_ready(nrdy0),
    .req1_valid(nv1), .req1_data(8'h20), .req1_last(1'b0), .req1_ready(nrdy1),
    .uart_wr(n_wr), .uart_tx_data(n_txd), .uart_busy(nbusy),
    .owner(n_owner), .locked(n_locked), .err_timeout(n_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_tx_data"}, txd, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int n, input logic [7:0] data, input logic last);
    int t;
    bit got;
    v[n] = 1'b1;
    d[n] = data;
    l[n] = last;
    t = 0;
    got = 0;
    while (!got && t < 300) begin
      @(negedge clk);
      if ((n == 0) ? rdy0 : rdy1) got = 1;
      else t++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: requester %0d byte %0h got no ready, want accept within 300 cycles", n, data);
    end
    @(posedge clk);
    #1;
    v[n] = 1'b0;
  endtask

  task automatic rand_req(input int n);
    int g, len;
    for (int m = 0; m < 10; m++) begin
      g = $urandom_range(0, 4);
      if (g > 0) settle(g);
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) settle($urandom_range(1, 2));
        send_byte(n, 8'($urandom), (i == len - 1));
      end
    end
  endtask

  // Buart stand-in: busy is high over a window fixed by the model at accept time.
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busy = (cyc >= b_start) && (cyc <= b_end);
    end
  end

  // Reference timeline: accept at N, strobe at N+1, free again at N+3+L,
  // or at N+17 with err_timeout when the transmitter never answers.
  always @(negedge clk) begin : model
    int   e, bl;
    bit   ok, can;
    exp_t it;
    if (reset) begin
      q.delete();
      m_locked = 0; m_owner = 0; m_rr = 0; m_data = 8'h00;
      free_cyc = 0; err_cyc = 32'h7fffffff; b_start = -1; b_end = -2;
    end else begin
      chk("locked", locked, m_locked);
      chk("owner", owner, m_owner);
      chk("err_timeout", err, cyc >= err_cyc);
      chk("tx_data_hold", txd, m_data);
      can = (cyc >= free_cyc) && !busy;
      ok = 0;
      e = 0;
      if (m_locked) begin
        e = m_owner; ok = v[m_owner];
      end else if (v[0] && v[1]) begin
        e = m_rr; ok = 1;
      end else if (v[1]) begin
        e = 1; ok = 1;
      end else if (v[0]) begin
        e = 0; ok = 1;
      end
      chk("ready0", rdy0, can && ok && e == 0);
      chk("ready1", rdy1, can && ok && e == 1);
      if (can && ok) begin
        it.data = d[e];
        it.own = (e == 1);
        it.wr_cyc = cyc + 1;
        q.push_back(it);
        m_data = d[e];
        m_owner = (e == 1);
        m_locked = !l[e];
        if (l[e]) m_rr = (e == 0);
        if (force_l >= 0) bl = force_l;
        else bl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
        if (bl == 0) begin
          free_cyc = cyc + 17;
          if (err_cyc > cyc + 17) err_cyc = cyc + 17;
        end else begin
          free_cyc = cyc + 3 + bl;
          b_start = cyc + 2;
          b_end = cyc + 1 + bl;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t it;
    if (!reset && wr) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got uart_wr=1 data %0h, want no strobe (cycle %0d)", txd, cyc);
      end else begin
        it = q.pop_front();
        chk("wr_data", txd, it.data);
        chk("wr_owner", owner, it.own);
        chk("wr_cycle", cyc, it.wr_cyc);
      end
      log_q.push_back(txd);
      wr_count++;
    end
  end

  initial begin
    nbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (n_wr) begin
        @(posedge clk);
        #1 nbusy = 1'b1;
        repeat (3) @(posedge clk);
        #1 nbusy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (nv0 && nrdy0) ng.push_back(0);
      if (nv1 && nrdy1) ng.push_back(1);
      if ((nv0 && nrdy0) || (nv1 && nrdy1)) begin
        chk("nl_locked", n_locked, 0);
        chk("nl_onehot", nrdy0 & nrdy1, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int w0;
    reset = 1'b1;
    v[0] = 0; v[1] = 0; d[0] = 0; d[1] = 0; l[0] = 0; l[1] = 0;
    nv0 = 0; nv1 = 0;
    #1;
    chk_reset_vals("reset");
    chk("reset_ready0", rdy0, 0);
    chk("reset_ready1", rdy1, 0);
    settle(2);
    reset = 1'b0;

    force_l = 10;
    fork
      send_byte(0, 8'h41, 1'b1);
      send_byte(1, 8'h42, 1'b1);
    join
    force_l = -1;
    settle(30);
    chk("rr_count", log_q.size(), 2);
    chk("rr_first", log_q[0], 8'h41);
    chk("rr_second", log_q[1], 8'h42);
    log_q.delete();

    fork
      begin
        send_byte(1, 8'h01, 1'b0);
        send_byte(1, 8'h02, 1'b0);
        send_byte(1, 8'h03, 1'b1);
      end
      begin
        settle(1);
        send_byte(0, 8'hAA, 1'b1);
      end
    join
    settle(30);
    chk("lock_count", log_q.size(), 4);
    chk("lock_b0", log_q[0], 8'h01);
    chk("lock_b1", log_q[1], 8'h02);
    chk("lock_b2", log_q[2], 8'h03);
    chk("lock_b3", log_q[3], 8'hAA);
    log_q.delete();

    force_l = 0;
    send_byte(0, 8'h55, 1'b1);
    force_l = -1;
    settle(25);
    chk("timeout_err", err, 1);
    send_byte(1, 8'h66, 1'b1);
    settle(30);
    chk("timeout_count", log_q.size(), 2);
    chk("timeout_b0", log_q[0], 8'h55);
    chk("timeout_b1", log_q[1], 8'h66);
    log_q.delete();

    force_l = 8;
    send_byte(0, 8'h77, 1'b0);
    force_l = -1;
    settle(3);
    chk("midreset_locked", locked, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    w0 = wr_count;
    settle(2);
    reset = 1'b0;
    settle(20);
    chk("midreset_no_wr", wr_count - w0, 0);
    log_q.delete();

    fork
      rand_req(0);
      rand_req(1);
    join
    settle(60);
    chk("sb_drained", q.size(), 0);

    nv0 = 1'b1;
    nv1 = 1'b1;
    settle(80);
    nv0 = 1'b0;
    nv1 = 1'b0;
    settle(20);
    chk("nl_count", ng.size() >= 6, 1);
    for (int i = 0; i < 6; i++) chk("nl_grant", ng[i], i % 2);
    chk("nl_owner", n_owner, ng[ng.size() - 1]);
    chk("nl_tx_data", n_txd, (ng[ng.size() - 1] == 1) ? 8'h20 : 8'h10);
    chk("nl_err", n_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter LOCK_EN, default 1: 1 = grant held from first byte to byte with last=1; 0 = arbitrate every byte.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15: max cycles waited for uart_busy to rise after uart_wr.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1 each  requester has a byte.
REQ-006 SHALL have ports req0_data / req1_data  input  8 each  byte to transmit.
REQ-007 SHALL have ports req0_last / req1_last  input  1 each  byte ends a message.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  byte accepted this cycle when valid&ready.
REQ-009 SHALL have port uart_wr  output  1  one-cycle write strobe to buart.
REQ-010 SHALL have port uart_tx_data  output  8  byte to buart, registered.
REQ-011 SHALL have port uart_busy  input  1  buart transmitter busy.
REQ-012 SHALL have port owner  output  1  index of current/last granted requester.
REQ-013 SHALL have port locked  output  1  message lock held.
REQ-014 SHALL have port err_timeout  output  1  sticky; set on busy timeout, cleared only by reset.

Function
REQ-015 SHALL implement FSM IDLE, SEND, WAIT_BUSY, WAIT_IDLE.
REQ-016 IDLE: readyN SHALL be combinational = (state==IDLE) & !uart_busy & (requester N is selected); at most one ready high per cycle.
REQ-017 Selection: if locked, only owner eligible; else if both valid, pick requester rr_ptr; else the single valid one.
REQ-018 On accept (valid&ready) SHALL capture data into uart_tx_data, set owner, go SEND.
REQ-019 SEND SHALL assert uart_wr for exactly one cycle (accept cycle N -> uart_wr at N+1), go WAIT_BUSY.
REQ-020 WAIT_BUSY: uart_busy=1 -> WAIT_IDLE; else count; after BUSY_TIMEOUT cycles without busy, set err_timeout and go IDLE.
REQ-021 WAIT_IDLE: uart_busy=0 -> IDLE; no timeout.
REQ-022 Lock (LOCK_EN=1): accepted byte with last=0 sets locked; last=1 clears locked.
REQ-023 rr_ptr SHALL toggle to the non-owner when a byte with last=1 is accepted, or every accepted byte when LOCK_EN=0.
REQ-024 Locked owner dropping valid SHALL NOT release lock; other requester stays stalled (ready=0).
REQ-025 Timeout SHALL NOT alter locked or rr_ptr; the byte counts as sent.
REQ-026 Timeout counter SHALL be 5 bits, saturating, cleared on entry to WAIT_BUSY.
REQ-027 uart_busy high in IDLE SHALL hold both ready low.

Reset
REQ-028 Reset SHALL force state IDLE, uart_wr=0, uart_tx_data=0, owner=0, rr_ptr=0, locked=0, err_timeout=0, counter=0.
REQ-029 Reset mid-transfer SHALL abandon the byte without a further uart_wr; outputs reach reset values asynchronously.

Structure
REQ-030 State encoding and BUSY_TIMEOUT width SHALL live in shared package uart_pkg.
REQ-031 Selection (REQ-017/023) SHALL be a sub-module rr_arb2: inputs valid[1:0], locked, owner, rr_ptr; output sel.
REQ-032 Block SHALL instantiate no buart; it drives buart wr/tx_data in the top.

Verification
REQ-033 Both valid, rr_ptr=0, req0_data=8'h41 last=1, req1_data=8'h42 last=1, busy model 10 cycles -> wr carries 8'h41 then 8'h42, owner 0 then 1.
REQ-034 req1 sends 3 bytes 8'h01,02,03 (last on 03) while req0 valid throughout -> req0_ready=0 until 8'h03 accepted; locked high during; req0 byte transmitted next.
REQ-035 Accept at cycle N -> uart_wr=1 only at N+1; uart_tx_data stable through WAIT_IDLE.
REQ-036 uart_busy never rises after wr -> err_timeout=1 at cycle N+1+15+1, FSM back to IDLE, next byte still served.
REQ-037 Assert reset in WAIT_IDLE with locked=1 -> all outputs reset values immediately; no uart_wr after release until new accept.
REQ-038 LOCK_EN=0, both valid continuously with last=0 -> grants alternate 0,1,0,1; locked stays 0.
